// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing
// with memory wait states, condition skip, wait timeout fault and retire count.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   op_i, funct_i, rd_i   instruction fields from the IR
//   cond_pass_i           condition check result, used in DECODE
//   mem_ready_i           memory access completes this cycle
//   mem_req_o, mem_w_o    memory request / write enable
//   adr_src_o             memory address select (0 PC, 1 ALU result)
//   ir_write_o, pc_write_o, reg_w_o, link_o   datapath strobes
//   alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o   datapath mux selects
//   state_o               current state code
//   fault_o               sticky fault flag
//   retired_o             count of completed instructions
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [1:0]       op_i,
    input  logic [5:0]       funct_i,
    input  logic [3:0]       rd_i,
    input  logic             cond_pass_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_w_o,
    output logic             adr_src_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             reg_w_o,
    output logic             link_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic             alu_op_o,
    output logic [1:0]       result_src_o,
    output logic [3:0]       state_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam int unsigned TO_W =
        (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_BRANCH   = 4'd5,
        S_MEMREAD  = 4'd6,
        S_MEMWRITE = 4'd7,
        S_ALUWB    = 4'd8,
        S_MEMWB    = 4'd9,
        S_FAULT    = 4'd10
    } state_e;

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic wait_st;
    logic timeout;
    logic no_wb;
    logic retire;
    logic strobe_en;

    logic req_raw, mw_raw, irw_raw, pcw_raw, rw_raw, lk_raw;

    assign wait_st = (state_q == S_FETCH) ||
                     (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE);

    assign timeout = (TIMEOUT != 0) && wait_st && !mem_ready_i &&
                     (to_cnt_q == TO_W'(TIMEOUT));

    // tst/teq/cmp/cmn only set flags: funct[4:1] = 10xx
    assign no_wb = funct_i[4] && !funct_i[3];

    // Reset and the timeout cycle both suppress every side effect.
    assign strobe_en = !reset_i && !timeout;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (timeout)          state_d = S_FAULT;
                else if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (!cond_pass_i) begin
                    state_d = S_FETCH;
                end else begin
                    unique case (1'b1)
                        (op_i == 2'b01):
                            state_d = S_MEMADDR;
                        (op_i == 2'b00) && !funct_i[5]:
                            state_d = S_EXEC_R;
                        (op_i == 2'b00) && funct_i[5]:
                            state_d = S_EXEC_I;
                        (op_i == 2'b10):
                            state_d = S_BRANCH;
                        default:
                            state_d = S_FAULT;
                    endcase
                end
            end
            S_MEMADDR:
                state_d = funct_i[0] ? S_MEMREAD : S_MEMWRITE;
            S_EXEC_R: state_d = S_ALUWB;
            S_EXEC_I: state_d = S_ALUWB;
            S_BRANCH: state_d = S_FETCH;
            S_MEMREAD: begin
                if (timeout)          state_d = S_FAULT;
                else if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                if (timeout)          state_d = S_FAULT;
                else if (mem_ready_i) state_d = S_FETCH;
            end
            S_ALUWB:  state_d = S_FETCH;
            S_MEMWB:  state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase
    end

    always_comb begin
        req_raw      = 1'b0;
        mw_raw       = 1'b0;
        irw_raw      = 1'b0;
        pcw_raw      = 1'b0;
        rw_raw       = 1'b0;
        lk_raw       = 1'b0;
        adr_src_o    = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 1'b0;
        result_src_o = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                req_raw      = 1'b1;
                alu_src_a_o  = 1'b1;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                irw_raw      = mem_ready_i;
                pcw_raw      = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
            end
            S_MEMADDR: alu_src_b_o = 2'b01;
            S_EXEC_R: begin
                alu_op_o    = 1'b1;
                alu_src_b_o = 2'b00;
            end
            S_EXEC_I: begin
                alu_op_o    = 1'b1;
                alu_src_b_o = 2'b01;
            end
            S_BRANCH: begin
                alu_src_b_o  = 2'b01;
                result_src_o = 2'b10;
                pcw_raw      = 1'b1;
                lk_raw       = funct_i[4];
                rw_raw       = funct_i[4];
            end
            S_MEMREAD: begin
                req_raw   = 1'b1;
                adr_src_o = 1'b1;
            end
            S_MEMWRITE: begin
                req_raw   = 1'b1;
                mw_raw    = 1'b1;
                adr_src_o = 1'b1;
            end
            S_ALUWB: begin
                result_src_o = 2'b00;
                rw_raw       = !no_wb;
                pcw_raw      = (rd_i == 4'd15) && !no_wb;
            end
            S_MEMWB: begin
                result_src_o = 2'b01;
                rw_raw       = 1'b1;
                pcw_raw      = (rd_i == 4'd15);
            end
            default: ;
        endcase
    end

    assign mem_req_o  = req_raw && strobe_en;
    assign mem_w_o    = mw_raw  && strobe_en;
    assign ir_write_o = irw_raw && strobe_en;
    assign pc_write_o = pcw_raw && strobe_en;
    assign reg_w_o    = rw_raw  && strobe_en;
    assign link_o     = lk_raw  && strobe_en;

    always_comb begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if ((TIMEOUT == 0) || !wait_st || mem_ready_i ||
            (state_d != state_q)) begin
            to_cnt_d = '0;
        end
    end

    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_BRANCH) ||
                     (state_q == S_MEMWRITE) ||
                     (state_q == S_ALUWB) ||
                     (state_q == S_MEMWB));

    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    assign fault_d   = fault_q || (state_d == S_FAULT);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_FETCH;
            to_cnt_q  <= '0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    assign state_o   = state_q;
    assign fault_o   = fault_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed and random instruction streams
// checked cycle by cycle against a per-instruction sequence model.
module tb_multicycle_ctrl;

    localparam int TO = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    op = '0;
    logic [5:0]    funct = '0;
    logic [3:0]    rd = '0;
    logic          cond_pass = 1'b1;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_w, adr_src, ir_write, pc_write;
    logic          reg_w, link, alu_src_a, alu_op, fault;
    logic [1:0]    alu_src_b, result_src;
    logic [3:0]    state;
    logic [CW-1:0] retired;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    logic [13:0] outv;
    assign outv = {mem_req, mem_w, adr_src, ir_write, pc_write, reg_w,
                   link, alu_src_a, alu_src_b, alu_op, result_src, fault};

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk), .reset_i(reset), .op_i(op), .funct_i(funct),
        .rd_i(rd), .cond_pass_i(cond_pass), .mem_ready_i(mem_ready),
        .mem_req_o(mem_req), .mem_w_o(mem_w), .adr_src_o(adr_src),
        .ir_write_o(ir_write), .pc_write_o(pc_write), .reg_w_o(reg_w),
        .link_o(link), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
        .alu_op_o(alu_op), .result_src_o(result_src), .state_o(state),
        .fault_o(fault), .retired_o(retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Output table for one cycle in a given state.
    function automatic logic [13:0] exp_out(input int st, input bit rdy,
                                            input bit to,
                                            input logic [5:0] f,
                                            input logic [3:0] r);
        bit mreq = 0, mw = 0, as = 0, irw = 0, pcw = 0, rw = 0, lk = 0;
        bit sa = 0, ao = 0, flt = 0;
        logic [1:0] sb = 2'd0, rs = 2'd0;
        bit nw = f[4:1] inside {4'b1000, 4'b1001, 4'b1010, 4'b1011};
        case (st)
            0: begin
                mreq = 1; sa = 1; sb = 2; rs = 2; irw = rdy; pcw = rdy;
            end
            1: begin sa = 1; sb = 2; rs = 2; end
            2: sb = 1;
            3: ao = 1;
            4: begin ao = 1; sb = 1; end
            5: begin sb = 1; rs = 2; pcw = 1; lk = f[4]; rw = f[4]; end
            6: begin mreq = 1; as = 1; end
            7: begin mreq = 1; mw = 1; as = 1; end
            8: begin rw = !nw; pcw = (r == 15) && !nw; end
            9: begin rs = 1; rw = 1; pcw = (r == 15); end
            10: flt = 1;
            default: flt = 1;
        endcase
        if (to) begin
            mreq = 0; mw = 0; irw = 0; pcw = 0; rw = 0; lk = 0;
        end
        return {mreq, mw, as, irw, pcw, rw, lk, sa, sb, ao, rs, flt};
    endfunction

    task automatic step(input int st, input bit rdy, input bit to,
                        input bit ret);
        mem_ready = rdy;
        @(negedge clk);
        chk("state", 32'(state), 32'(st));
        chk("outputs", 32'(outv), 32'(exp_out(st, rdy, to, funct, rd)));
        chk("retired", 32'(retired), 32'(exp_ret));
        @(posedge clk);
        #1;
        if (ret) exp_ret = (exp_ret + 1) % (1 << CW);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            chk("reset_strobes",
                32'({mem_req, mem_w, ir_write, pc_write, reg_w, link}), 0);
            if (i > 0) begin
                chk("reset_state", 32'(state), 0);
                chk("reset_retired", 32'(retired), 0);
                chk("reset_fault", 32'(fault), 0);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        exp_ret = 0;
    endtask

    // One memory access: w wait cycles then completion, unless the
    // wait run exceeds the timeout.
    task automatic mem_phase(input int code, input int w, input bit ret,
                             output bit flt);
        flt = 0;
        for (int j = 0; j < w; j++) begin
            if (j == TO) begin
                step(code, 0, 1, 0);
                flt = 1;
                return;
            end
            step(code, 0, 0, 0);
        end
        step(code, 1, 0, ret);
    endtask

    task automatic fault_tail();
        step(10, 0, 0, 0);
        step(10, 1, 0, 0);
        step(10, 1'($urandom), 0, 0);
        do_reset(2);
    endtask

    task automatic run_instr(input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input bit c,
                             input int wf, input int wm);
        bit flt;
        op = o; funct = f; rd = r; cond_pass = c;
        mem_phase(0, wf, 0, flt);
        if (flt) begin fault_tail(); return; end
        step(1, 1'($urandom), 0, 0);
        if (!c) return;
        case (o)
            2'b00: begin
                step(f[5] ? 4 : 3, 1'($urandom), 0, 0);
                step(8, 1'($urandom), 0, 1);
            end
            2'b01: begin
                step(2, 1'($urandom), 0, 0);
                if (f[0]) begin
                    mem_phase(6, wm, 0, flt);
                    if (!flt) step(9, 1'($urandom), 0, 1);
                end else begin
                    mem_phase(7, wm, 1, flt);
                end
                if (flt) fault_tail();
            end
            2'b10: step(5, 1'($urandom), 0, 1);
            default: fault_tail();
        endcase
    endtask

    initial begin
        do_reset(2);

        run_instr(2'b00, 6'b001000, 4'd3, 1, 0, 0);
        chk("alu_retired", 32'(retired), 1);
        run_instr(2'b01, 6'b000001, 4'd15, 1, 0, 3);
        run_instr(2'b00, 6'b010101, 4'd3, 1, 0, 0);
        run_instr(2'b00, 6'b001000, 4'd3, 0, 0, 0);
        run_instr(2'b10, 6'b010000, 4'd14, 1, 0, 0);
        run_instr(2'b10, 6'b000000, 4'd14, 1, 0, 0);
        run_instr(2'b01, 6'b000000, 4'd2, 1, 2, 1);
        run_instr(2'b00, 6'b101001, 4'd15, 1, 0, 0);

        run_instr(2'b00, 6'b001000, 4'd1, 1, 6, 0);
        run_instr(2'b11, 6'b000000, 4'd1, 1, 0, 0);
        run_instr(2'b01, 6'b000001, 4'd1, 1, 0, 5);

        do_reset(2);
        for (int i = 0; i < 8; i++)
            run_instr(2'b00, 6'b001000, 4'd4, 1, 0, 0);
        chk("wrap_retired", 32'(retired), 0);

        op = 2'b01; funct = 6'b000000; rd = 4'd2; cond_pass = 1;
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(2, 1, 0, 0);
        step(7, 0, 0, 0);
        reset = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("midreset_mem_w", 32'(mem_w), 0);
        chk("midreset_mem_req", 32'(mem_req), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_ret = 0;
        run_instr(2'b00, 6'b100000, 4'd5, 1, 0, 0);

        for (int n = 0; n < 300; n++) begin
            logic [1:0] o;
            int wf, wm, mx;
            o = ($urandom_range(0, 29) == 0) ? 2'b11 :
                2'($urandom_range(0, 2));
            mx = ($urandom_range(0, 19) == 0) ? 6 : 2;
            wf = $urandom_range(0, mx);
            wm = $urandom_range(0, mx);
            run_instr(o, 6'($urandom), 4'($urandom),
                      $urandom_range(0, 4) != 0, wf, wm);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
